// File: rtl/bingo_pkg.sv
// Shared constants, FSM state type and cell indexing for the bingo map writer.
// The optional line counter is enabled with the BINGO_LINES_EN macro.
package bingo_pkg;

    localparam int N     = 5;
    localparam int CELLS = N * N;
    localparam int VW    = 5;

    localparam logic [VW-1:0] MAX_VAL  = VW'(CELLS);
    localparam logic [VW-1:0] LAST_IDX = VW'(CELLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2,
        SCAN = 2'd3
    } state_t;

    function automatic int cell_idx(input int x, input int y);
        return x + N * y;
    endfunction

endpackage

// File: rtl/bingo_line_counter.sv
// Counts fully marked rows, columns and diagonals of the bingo map (0..12).
// Only instantiated when BINGO_LINES_EN is defined.
module bingo_line_counter
    import bingo_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clear,
    input  logic                i_en,
    input  logic [VW*CELLS-1:0] i_map,
    output logic [3:0]          o_lines
);

    logic [3:0] w_count;
    logic       w_row_full;
    logic       w_col_full;
    logic       w_diag0;
    logic       w_diag1;

    function automatic logic marked(input logic [VW*CELLS-1:0] m, input int x, input int y);
        return m[VW*cell_idx(x, y) +: VW] == '0;
    endfunction

    always_comb begin
        w_count    = '0;
        w_row_full = 1'b1;
        w_col_full = 1'b1;
        w_diag0    = 1'b1;
        w_diag1    = 1'b1;
        for (int a = 0; a < N; a++) begin
            w_row_full = 1'b1;
            w_col_full = 1'b1;
            for (int b = 0; b < N; b++) begin
                w_row_full &= marked(i_map, b, a);
                w_col_full &= marked(i_map, a, b);
            end
            w_count += {3'b000, w_row_full} + {3'b000, w_col_full};
            w_diag0 &= marked(i_map, a, a);
            w_diag1 &= marked(i_map, N - 1 - a, a);
        end
        w_count += {3'b000, w_diag0} + {3'b000, w_diag1};
    end

    // An unfilled board is all zeros, so counting is only meaningful once filled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_lines <= '0;
        else if (i_clear || !i_en)
            o_lines <= '0;
        else
            o_lines <= w_count;
    end

endmodule

// File: rtl/bingo_map_writer.sv
// Writer side of the packed 5x5 bingo map: fills cells with checked numbers,
// then clears called numbers by a one-cell-per-cycle scan. Optional: BINGO_LINES_EN.
module bingo_map_writer
    import bingo_pkg::*;
(
    input  logic                clk_25MHz,
    input  logic                all_rst,
    input  logic                clear,
    input  logic                start,
    input  logic                in_valid,
    input  logic [VW-1:0]       in_value,
    output logic                in_ready,
    input  logic                mark_valid,
    input  logic [VW-1:0]       mark_value,
    output logic                mark_ready,
    output logic [VW*CELLS-1:0] map,
    output logic [VW-1:0]       cursor,
    output logic                fill_done,
    output logic                in_err,
    output logic                mark_hit,
    output logic                mark_miss,
    output logic [3:0]          lines
);

    state_t         r_state;
    state_t         w_state_next;
    logic [VW-1:0]  r_cells [CELLS];
    logic [CELLS-1:0] r_used;
    logic [VW-1:0]  r_cursor;
    logic [VW-1:0]  r_idx;
    logic [VW-1:0]  r_mark_val;
    logic           r_in_err;
    logic           r_mark_miss;

    logic           w_fill_acc;
    logic           w_fill_legal;
    logic [VW-1:0]  w_vidx;
    logic           w_mark_acc;
    logic           w_mark_bad;
    logic           w_scan_hit;
    logic           w_scan_last;

    assign w_vidx       = in_value - VW'(1);
    assign w_fill_acc   = (r_state == FILL) && in_valid;
    assign w_fill_legal = (in_value != '0) && (in_value <= MAX_VAL) && !r_used[w_vidx];
    assign w_mark_acc   = (r_state == PLAY) && mark_valid && !start;
    assign w_mark_bad   = (mark_value == '0) || (mark_value > MAX_VAL);
    assign w_scan_hit   = (r_state == SCAN) && (r_cells[r_idx] == r_mark_val);
    assign w_scan_last  = (r_state == SCAN) && (r_idx == LAST_IDX);

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        in_ready     = (r_state == FILL);
        mark_ready   = (r_state == PLAY);
        fill_done    = (r_state == PLAY) || (r_state == SCAN);
        in_err       = r_in_err;
        mark_hit     = w_scan_hit;
        mark_miss    = r_mark_miss || (w_scan_last && !w_scan_hit);
        unique case (r_state)
            IDLE: if (start) w_state_next = FILL;
            FILL: if (w_fill_acc && w_fill_legal && r_cursor == LAST_IDX) w_state_next = PLAY;
            PLAY: begin
                if (start)
                    w_state_next = FILL;
                else if (w_mark_acc && !w_mark_bad)
                    w_state_next = SCAN;
            end
            SCAN: if (w_scan_hit || w_scan_last) w_state_next = PLAY;
            default: w_state_next = IDLE;
        endcase
        if (clear)
            w_state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_25MHz or negedge all_rst) begin
        if (!all_rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // NOTE: the cell array is reset because it drives the renderer's map bus directly.
    always_ff @(posedge clk_25MHz or negedge all_rst) begin
        if (!all_rst) begin
            for (int i = 0; i < CELLS; i++) r_cells[i] <= '0;
            r_used      <= '0;
            r_cursor    <= '0;
            r_idx       <= '0;
            r_mark_val  <= '0;
            r_in_err    <= 1'b0;
            r_mark_miss <= 1'b0;
        end else begin
            r_in_err    <= 1'b0;
            r_mark_miss <= 1'b0;
            if (clear || (r_state == PLAY && start)) begin
                for (int i = 0; i < CELLS; i++) r_cells[i] <= '0;
                r_used   <= '0;
                r_cursor <= '0;
                r_idx    <= '0;
            end else begin
                unique case (r_state)
                    FILL: begin
                        if (w_fill_acc && w_fill_legal) begin
                            r_cells[r_cursor] <= in_value;
                            r_used[w_vidx]    <= 1'b1;
                            r_cursor          <= r_cursor + VW'(1);
                        end else if (w_fill_acc) begin
                            r_in_err <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (w_mark_acc && w_mark_bad) begin
                            r_mark_miss <= 1'b1;
                        end else if (w_mark_acc) begin
                            r_mark_val <= mark_value;
                            r_idx      <= '0;
                        end
                    end
                    SCAN: begin
                        if (w_scan_hit)
                            r_cells[r_idx] <= '0;
                        else
                            r_idx <= r_idx + VW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < CELLS; i++) begin : g_pack
        assign map[VW*i +: VW] = r_cells[i];
    end

    assign cursor = r_cursor;

`ifdef BINGO_LINES_EN
    bingo_line_counter u_line_counter (
        .i_clk   (clk_25MHz),
        .i_rst_n (all_rst),
        .i_clear (clear),
        .i_en    (fill_done),
        .i_map   (map),
        .o_lines (lines)
    );
`else
    assign lines = 4'd0;
`endif

endmodule

// File: tb/tb_bingo_map_writer.sv
// Directed self-checking bench for bingo_map_writer: fill, range/duplicate errors,
// scan timing for hits and misses, restart, async reset, optional line count.
module tb_bingo_map_writer;

    logic         clk_25MHz = 1'b0;
    logic         all_rst;
    logic         clear;
    logic         start;
    logic         in_valid;
    logic [4:0]   in_value;
    logic         in_ready;
    logic         mark_valid;
    logic [4:0]   mark_value;
    logic         mark_ready;
    logic [124:0] map;
    logic [4:0]   cursor;
    logic         fill_done;
    logic         in_err;
    logic         mark_hit;
    logic         mark_miss;
    logic [3:0]   lines;

    int checks = 0;
    int errors = 0;
    int rdy_cnt;
    int err_cnt;
    int hit_at;
    int miss_at;
    int rdy_at;
    logic [3:0]   lines_at [31];
    logic [124:0] exp_map;
    logic [4:0]   bad_v [3];

    bingo_map_writer dut (
        .clk_25MHz  (clk_25MHz),
        .all_rst    (all_rst),
        .clear      (clear),
        .start      (start),
        .in_valid   (in_valid),
        .in_value   (in_value),
        .in_ready   (in_ready),
        .mark_valid (mark_valid),
        .mark_value (mark_value),
        .mark_ready (mark_ready),
        .map        (map),
        .cursor     (cursor),
        .fill_done  (fill_done),
        .in_err     (in_err),
        .mark_hit   (mark_hit),
        .mark_miss  (mark_miss),
        .lines      (lines)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic fill_value(input logic [4:0] v);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk_25MHz);
        if (in_ready) rdy_cnt++;
        if (in_err) err_cnt++;
        step();
    endtask

    task automatic mark_watch(input logic [4:0] v);
        hit_at  = -1;
        miss_at = -1;
        rdy_at  = -1;
        mark_valid = 1'b1;
        mark_value = v;
        step();
        mark_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_25MHz);
            if (mark_hit && hit_at < 0) hit_at = c;
            if (mark_miss && miss_at < 0) miss_at = c;
            if (mark_ready && rdy_at < 0) rdy_at = c;
            lines_at[c] = lines;
            step();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   in_ready,   1'b0);
        check({tag, "_mark_ready"}, mark_ready, 1'b0);
        check({tag, "_fill_done"},  fill_done,  1'b0);
        check({tag, "_map"},        map,        125'd0);
        check({tag, "_cursor"},     cursor,     5'd0);
        check({tag, "_pulses"},     {in_err, mark_hit, mark_miss}, 3'b000);
        check({tag, "_lines"},      lines,      4'd0);
    endtask

    initial begin
        all_rst = 1'b0; clear = 1'b0; start = 1'b0;
        in_valid = 1'b0; in_value = '0; mark_valid = 1'b0; mark_value = '0;
        bad_v[0] = 5'd0; bad_v[1] = 5'd26; bad_v[2] = 5'd7;
        #50;
        check_all_zero("reset");
        @(negedge clk_25MHz);
        all_rst = 1'b1;
        step();

        // IDLE ignores fill data; clear beats start
        in_valid = 1'b1; in_value = 5'd5;
        step();
        in_valid = 1'b0;
        @(negedge clk_25MHz);
        check("idle_ignore_cursor", cursor, 5'd0);
        step();
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        @(negedge clk_25MHz);
        check("clear_beats_start", in_ready, 1'b0);
        step();

        // Full fill 25..1 with in_valid held
        start = 1'b1;
        step();
        start = 1'b0;
        rdy_cnt = 0; err_cnt = 0;
        for (int v = 25; v >= 1; v--) fill_value(5'(v));
        in_valid = 1'b0;
        @(negedge clk_25MHz);
        for (int i = 0; i < 25; i++) exp_map[5*i +: 5] = 5'(25 - i);
        check("fill_ready_cycles", rdy_cnt, 25);
        check("fill_no_err", err_cnt, 0);
        check("fill_map", map, exp_map);
        check("fill_cell0", map[4:0], 5'd25);
        check("fill_cell24", map[124:120], 5'd1);
        check("fill_cursor", cursor, 5'd25);
        check("fill_done", fill_done, 1'b1);
        check("fill_in_ready_low", in_ready, 1'b0);
        check("play_mark_ready", mark_ready, 1'b1);
        step();

        // Restart from PLAY; a simultaneous mark must be dropped
        start = 1'b1; mark_valid = 1'b1; mark_value = 5'd13;
        step();
        start = 1'b0; mark_valid = 1'b0;
        @(negedge clk_25MHz);
        check("restart_map", map, 125'd0);
        check("restart_cursor", cursor, 5'd0);
        check("restart_in_ready", in_ready, 1'b1);
        check("restart_no_mark", {mark_hit, mark_miss, fill_done}, 3'b000);
        step();

        // Partial fill, then illegal values 0, 26, duplicate 7
        rdy_cnt = 0; err_cnt = 0;
        for (int v = 25; v >= 7; v--) fill_value(5'(v));
        check("partial_no_err", err_cnt, 0);
        exp_map = '0;
        for (int i = 0; i < 19; i++) exp_map[5*i +: 5] = 5'(25 - i);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_value = bad_v[b];
            step();
            in_valid = 1'b0;
            @(negedge clk_25MHz);
            check($sformatf("bad%0d_err", bad_v[b]), in_err, 1'b1);
            check($sformatf("bad%0d_cursor", bad_v[b]), cursor, 5'd19);
            check($sformatf("bad%0d_map", bad_v[b]), map, exp_map);
            step();
            @(negedge clk_25MHz);
            check($sformatf("bad%0d_err_single", bad_v[b]), in_err, 1'b0);
            step();
        end
        for (int v = 6; v >= 1; v--) fill_value(5'(v));
        in_valid = 1'b0;
        for (int i = 0; i < 25; i++) exp_map[5*i +: 5] = 5'(25 - i);
        @(negedge clk_25MHz);
        check("refill_map", map, exp_map);
        check("refill_cursor", cursor, 5'd25);
        step();

        // Mark 13 (cell 12): hit at T+13, ready at T+14
        mark_watch(5'd13);
        exp_map[60 +: 5] = 5'd0;
        check("m13_hit_at", hit_at, 13);
        check("m13_no_miss", miss_at, -1);
        check("m13_ready_at", rdy_at, 14);
        check("m13_map", map, exp_map);

        // Mark 13 again: already marked, full scan miss at T+25
        mark_watch(5'd13);
        check("m13b_miss_at", miss_at, 25);
        check("m13b_no_hit", hit_at, -1);
        check("m13b_ready_at", rdy_at, 26);
        check("m13b_map", map, exp_map);

        // Out-of-range marks miss next cycle without scanning
        mark_watch(5'd0);
        check("m0_miss_at", miss_at, 1);
        check("m0_ready_at", rdy_at, 1);
        mark_watch(5'd31);
        check("m31_miss_at", miss_at, 1);
        check("m31_no_hit", hit_at, -1);

        // Boundary cells: last (value 1) and first (value 25)
        mark_watch(5'd1);
        exp_map[120 +: 5] = 5'd0;
        check("m1_hit_at", hit_at, 25);
        check("m1_ready_at", rdy_at, 26);
        mark_watch(5'd25);
        exp_map[0 +: 5] = 5'd0;
        check("m25_hit_at", hit_at, 1);
        check("m25_ready_at", rdy_at, 2);
        check("m25_map", map, exp_map);

        // Complete row 0 (cell 0 already marked), then column 0
        mark_watch(5'd24);
        mark_watch(5'd23);
        mark_watch(5'd22);
        mark_watch(5'd21);
        check("row0_hit_at", hit_at, 5);
`ifdef BINGO_LINES_EN
        check("row0_lines_before", lines_at[6], 4'd0);
        check("row0_lines_after", lines_at[7], 4'd1);
`else
        check("row0_lines_tied", lines_at[7], 4'd0);
`endif
        mark_watch(5'd20);
        mark_watch(5'd15);
        mark_watch(5'd10);
        mark_watch(5'd5);
        check("col0_hit_at", hit_at, 21);
`ifdef BINGO_LINES_EN
        check("col0_lines_before", lines_at[22], 4'd1);
        check("col0_lines_after", lines_at[23], 4'd2);
`else
        check("col0_lines_tied", lines_at[23], 4'd0);
`endif

        // Async reset in the middle of a scan (value 2 lives in cell 23)
        mark_valid = 1'b1; mark_value = 5'd2;
        step();
        mark_valid = 1'b0;
        repeat (5) @(posedge clk_25MHz);
        #5 all_rst = 1'b0;
        #1 check_all_zero("rst_scan");
        @(negedge clk_25MHz);
        all_rst = 1'b1;
        step();

        // Async reset in the middle of a fill
        start = 1'b1;
        step();
        start = 1'b0;
        fill_value(5'd3);
        fill_value(5'd9);
        fill_value(5'd17);
        in_valid = 1'b0;
        @(negedge clk_25MHz);
        check("prefill_cursor", cursor, 5'd3);
        step();
        #5 all_rst = 1'b0;
        #1 check_all_zero("rst_fill");
        @(negedge clk_25MHz);
        all_rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
